// File: rtl/cla_shared_adder_ctrl.sv
// Shares one external 4-bit CLA between two requesters to build a WIDTH-bit add.
// Latency: acceptance edge + WIDTH/4 nibble edges, then response held in RESP.
// Backpressure: rsp_ready low holds RESP indefinitely; both request readies stay 0.
module cla_shared_adder_ctrl #(
  parameter int WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_id;
  logic             r_id;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_rsp_valid;

  logic             w_idle;
  logic             w_add;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;
  logic [WIDTH-1:0] w_opa_sh;
  logic [WIDTH-1:0] w_opb_sh;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  assign w_idle     = (r_state == S_IDLE);
  assign w_add      = (r_state == S_ADD);
  assign w_gnt0     = req0_valid && (!req1_valid || r_last_id);
  assign w_gnt1     = req1_valid && (!req0_valid || !r_last_id);
  assign req0_ready = w_idle && w_gnt0;
  assign req1_ready = w_idle && w_gnt1;
  assign w_acc      = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Current nibble is brought to bit 0 so the CLA operands are a fixed 4-bit slice.
  assign w_opa_sh = r_opa >> {r_cnt, 2'b00};
  assign w_opb_sh = r_opb >> {r_cnt, 2'b00};
  assign cla_a    = w_add ? w_opa_sh[3:0] : 4'h0;
  assign cla_b    = w_add ? w_opb_sh[3:0] : 4'h0;
  assign cla_cin  = w_add ? r_carry : 1'b0;

  // The response fields are the working registers themselves, frozen while in RESP.
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_res;
  assign rsp_cout  = r_carry;
  assign rsp_id    = r_id;

  // Sequencer: accept one request, ripple the carry through NIB CLA steps, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_id   <= 1'b1;
      r_id        <= 1'b0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_res       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_opa   <= req1_ready ? req1_a   : req0_a;
            r_opb   <= req1_ready ? req1_b   : req0_b;
            r_carry <= req1_ready ? req1_cin : req0_cin;
            r_id    <= req1_ready;
            r_cnt   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_res[{r_cnt, 2'b00} +: 4] <= cla_sum;
          r_carry                    <= cla_cout;
          if (r_cnt == LAST_NIB) begin
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_last_id   <= r_id;
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_shared_adder_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
// Two instances: WIDTH=16 (main) and WIDTH=8, each with its own behavioural 4-bit CLA.
module tb_cla_shared_adder_ctrl;

  typedef struct packed {
    logic        id;
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_t q16[$];
  exp_t q8[$];

  // WIDTH=16 instance signals
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_cin = 1'b0, req1_cin = 1'b0;
  logic        rsp_valid, rsp_id, rsp_cout;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_sum;
  logic [3:0]  cla_a, cla_b, cla_sum;
  logic        cla_cin, cla_cout;

  // WIDTH=8 instance signals
  logic        d8_req0_valid = 1'b0;
  logic        d8_req0_ready, d8_req1_ready;
  logic [7:0]  d8_req0_a = '0, d8_req0_b = '0;
  logic        d8_req0_cin = 1'b0;
  logic        d8_rsp_valid, d8_rsp_id, d8_rsp_cout;
  logic        d8_rsp_ready = 1'b1;
  logic [7:0]  d8_rsp_sum;
  logic [3:0]  d8_cla_a, d8_cla_b, d8_cla_sum;
  logic        d8_cla_cin, d8_cla_cout;

  assign {cla_cout, cla_sum}       = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};
  assign {d8_cla_cout, d8_cla_sum} = {1'b0, d8_cla_a} + {1'b0, d8_cla_b} + {4'b0, d8_cla_cin};

  cla_shared_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin), .cla_sum(cla_sum), .cla_cout(cla_cout)
  );

  cla_shared_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(d8_req0_valid), .req0_ready(d8_req0_ready), .req0_a(d8_req0_a), .req0_b(d8_req0_b),
    .req0_cin(d8_req0_cin),
    .req1_valid(1'b0), .req1_ready(d8_req1_ready), .req1_a(8'h00), .req1_b(8'h00), .req1_cin(1'b0),
    .rsp_valid(d8_rsp_valid), .rsp_ready(d8_rsp_ready), .rsp_id(d8_rsp_id), .rsp_sum(d8_rsp_sum),
    .rsp_cout(d8_rsp_cout),
    .cla_a(d8_cla_a), .cla_b(d8_cla_b), .cla_cin(d8_cla_cin), .cla_sum(d8_cla_sum), .cla_cout(d8_cla_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         acc16 = 0, acc8 = 0, last_acc = -1;
  bit         rate_on = 1'b0;
  logic       prev16 = 1'b0, prev8 = 1'b0;
  logic       held_vld = 1'b0;
  logic [17:0] held = '0;
  exp_t       e16, e8;

  always @(negedge clk) begin
    if (rst_n && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
      acc16 = cyc + 1;
      if (rate_on) begin
        if (last_acc >= 0) chk("accept_period", acc16 - last_acc, 6);
        last_acc = acc16;
      end
    end
    if (rsp_valid && !prev16) chk("latency16", cyc - acc16, 4);
    prev16 = rsp_valid;
    if (rsp_valid) begin
      chk("ready_in_resp", {30'b0, req0_ready, req1_ready}, 0);
      if (held_vld) chk("stall_stable", {14'b0, rsp_id, rsp_sum, rsp_cout}, {14'b0, held});
      held     = {rsp_id, rsp_sum, rsp_cout};
      held_vld = !rsp_ready;
      if (rsp_ready) begin
        if (q16.size() == 0) chk("unexpected_rsp16", 1, 0);
        else begin
          e16 = q16.pop_front();
          chk("rsp16", {14'b0, rsp_id, rsp_cout, rsp_sum}, {14'b0, e16.id, e16.cout, e16.sum});
        end
      end
    end else held_vld = 1'b0;

    if (rst_n && d8_req0_valid && d8_req0_ready) acc8 = cyc + 1;
    if (d8_rsp_valid && !prev8) chk("latency8", cyc - acc8, 2);
    prev8 = d8_rsp_valid;
    if (d8_rsp_valid && d8_rsp_ready) begin
      if (q8.size() == 0) chk("unexpected_rsp8", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("rsp8", {14'b0, d8_rsp_id, d8_rsp_cout, 8'h00, d8_rsp_sum}, {14'b0, e8.id, e8.cout, e8.sum});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push16(input logic id, input logic [15:0] sum, input logic cout);
    exp_t e;
    e.id = id; e.sum = sum; e.cout = cout;
    q16.push_back(e);
  endtask

  task automatic drive(input bit r, input logic [15:0] a, input logic [15:0] b, input logic c);
    bit ok = 1'b0;
    if (!r) begin req0_a = a; req0_b = b; req0_cin = c; req0_valid = 1'b1; end
    else    begin req1_a = a; req1_b = b; req1_cin = c; req1_valid = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((!r && req0_ready) || (r && req1_ready)) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    #1;
    if (!r) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q16.size() == 0 && q8.size() == 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    exp_t e;
    bit seen;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("reset_rsp_fields", {14'b0, rsp_id, rsp_cout, rsp_sum}, 0);
    chk("reset_cla_outputs", {23'b0, cla_a, cla_b, cla_cin}, 0);
    chk("reset_readies", {30'b0, req0_ready, req1_ready}, 0);
    chk("reset_rsp8_valid", {31'b0, d8_rsp_valid}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request from requester 0
    push16(1'b0, 16'h5555, 1'b0);
    drive(1'b0, 16'h1234, 16'h4321, 1'b0);
    drain();

    // Carry ripples through every nibble
    push16(1'b1, 16'h0000, 1'b1);
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("chain_cla_cin", {31'b0, cla_cin}, 1);
      chk("chain_cla_a", {28'b0, cla_a}, 32'hF);
      @(posedge clk); #1;
    end
    chk("resp_cla_cin_zero", {31'b0, cla_cin}, 0);
    drain();

    // Fairness: both requesters continuously valid, grants alternate from 0
    do_reset();
    push16(1'b0, 16'h3333, 1'b0);
    push16(1'b1, 16'h0001, 1'b1);
    push16(1'b0, 16'hBE02, 1'b0);
    push16(1'b1, 16'h0000, 1'b1);
    last_acc = -1;
    rate_on  = 1'b1;
    fork
      begin drive(1'b0, 16'h1111, 16'h2222, 1'b0); drive(1'b0, 16'hABCD, 16'h1234, 1'b1); end
      begin drive(1'b1, 16'h8000, 16'h8000, 1'b1); drive(1'b1, 16'hF0F0, 16'h0F10, 1'b0); end
    join
    drain();
    rate_on = 1'b0;

    // Backpressure: hold rsp_ready low in RESP while requester 1 waits
    rsp_ready = 1'b0;
    push16(1'b0, 16'h8000, 1'b0);
    push16(1'b1, 16'h0008, 1'b0);
    fork
      drive(1'b0, 16'h7FFF, 16'h0001, 1'b0);
      drive(1'b1, 16'h0003, 16'h0004, 1'b1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(posedge clk); #1;
          if (rsp_valid) begin seen = 1'b1; break; end
        end
        chk("bp_rsp_seen", {31'b0, seen}, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_still_valid", {31'b0, rsp_valid}, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_delivered", {31'b0, rsp_valid}, 0);
      end
    join
    drain();

    // Reset after two nibbles captured: in-flight operation is dropped
    drive(1'b0, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", {31'b0, rsp_valid}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_reset", {31'b0, rsp_valid}, 0);
    end
    push16(1'b0, 16'h0100, 1'b0);
    drive(1'b0, 16'h00FF, 16'h0001, 1'b0);
    drain();

    // WIDTH=8 instance
    e.id = 1'b0; e.sum = 16'h0000; e.cout = 1'b1;
    q8.push_back(e);
    d8_req0_a = 8'hA5; d8_req0_b = 8'h5B; d8_req0_cin = 1'b0; d8_req0_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d8_req0_ready) begin seen = 1'b1; break; end
    end
    if (seen) @(posedge clk);
    #1;
    d8_req0_valid = 1'b0;
    chk("d8_accepted", {31'b0, seen}, 1);
    drain();

    chk("queues_drained", q16.size() + q8.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
